// File: rtl/field_snapshot_buffer_pkg.sv
// ============================================================================
// Module      : field_snapshot_buffer_pkg
// Description : Shared default sizes and helpers for the field snapshot buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package field_snapshot_buffer_pkg;

    localparam int FSB_DATA_WIDTH    = 16;
    localparam int FSB_NUM_CH        = 3;
    localparam int FSB_DEPTH         = 64;
    localparam int FSB_ADDRESS_WIDTH = 6;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/field_snapshot_buffer_snapshot_bank.sv
// ============================================================================
// Module      : snapshot_bank
// Description : One frame bank: simple 1W/1R synchronous RAM, one pixel/word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snapshot_bank
    import field_snapshot_buffer_pkg::*;
#(
    parameter int WIDTH         = FSB_NUM_CH * FSB_DATA_WIDTH,
    parameter int DEPTH         = FSB_DEPTH,
    parameter int ADDRESS_WIDTH = FSB_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/field_snapshot_buffer.sv
// ============================================================================
// Module      : field_snapshot_buffer
// Description : Ping-pong frame buffer between the collider stream and a host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_snapshot_buffer
    import field_snapshot_buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = FSB_DATA_WIDTH,
    parameter int NUM_CH        = FSB_NUM_CH,
    parameter int DEPTH         = FSB_DEPTH,
    parameter int ADDRESS_WIDTH = FSB_ADDRESS_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    input  logic                           host_lock,
    input  logic                           host_rd_en,
    input  logic [ADDRESS_WIDTH-1:0]       host_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   host_data,
    output logic                           host_valid,
    output logic                           frame_ready,
    output logic [15:0]                    frame_seq,
    output logic [15:0]                    drop_count,
    output logic                           sync_err
);

    localparam int WORD_W = NUM_CH * DATA_WIDTH;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     lock_q, lock_d;
    logic                     frame_ready_q, frame_ready_d;
    logic [15:0]              frame_seq_q, frame_seq_d;
    logic [15:0]              drop_count_q, drop_count_d;
    logic                     sync_err_q, sync_err_d;
    logic                     host_valid_q, host_valid_d;
    logic                     rd_bank_q, rd_bank_d;
    logic                     rd_zero_q, rd_zero_d;

    logic                     w_wr_en;
    logic [ADDRESS_WIDTH-1:0] w_wr_addr;
    logic                     w_complete;
    logic                     w_last;
    logic                     w_rd_oor;
    logic                     w_re0, w_re1, w_we0, w_we1;
    logic [WORD_W-1:0]        w_rdata0, w_rdata1;

    assign w_last   = (32'(wr_ptr_q) == DEPTH - 1);
    assign w_rd_oor = (32'(host_addr) >= DEPTH);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        frame_ready_d = frame_ready_q;
        frame_seq_d   = frame_seq_q;
        drop_count_d  = drop_count_q;
        sync_err_d    = sync_err_q;
        lock_d        = host_lock;
        w_wr_en       = 1'b0;
        w_wr_addr     = '0;
        w_complete    = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (in_valid && in_sof) begin
                    w_wr_en  = 1'b1;
                    wr_ptr_d = ADDRESS_WIDTH'(1);
                    state_d  = c_st_fill;
                end
            end
            c_st_fill: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (in_sof) begin
                        // Resynchronise: the partial frame is dropped and
                        // this beat becomes pixel 0 of a new frame.
                        sync_err_d = 1'b1;
                        wr_ptr_d   = ADDRESS_WIDTH'(1);
                    end else begin
                        w_wr_addr  = wr_ptr_q;
                        wr_ptr_d   = wr_ptr_q + ADDRESS_WIDTH'(1);
                        w_complete = w_last;
                    end
                end
            end
            c_st_hold: begin
                if (in_valid && in_sof) begin
                    drop_count_d = sat_inc16(drop_count_q);
                end
                w_complete = 1'b1;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // A lock rise implies host_lock=1, so it always beats a pending swap.
        if (w_complete) begin
            if (host_lock) begin
                state_d = c_st_hold;
            end else begin
                wr_bank_d     = ~wr_bank_q;
                frame_ready_d = 1'b1;
                frame_seq_d   = frame_seq_q + 16'd1;
                wr_ptr_d      = '0;
                state_d       = c_st_idle;
            end
        end

        if (host_lock && !lock_q) begin
            frame_ready_d = 1'b0;
        end
    end

    // Read side: remember which bank and whether the address was valid.
    always_comb begin
        host_valid_d = host_rd_en;
        rd_bank_d    = rd_bank_q;
        rd_zero_d    = rd_zero_q;
        if (host_rd_en) begin
            rd_bank_d = ~wr_bank_q;
            rd_zero_d = w_rd_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= c_st_idle;
            wr_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            lock_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_seq_q   <= 16'd0;
            drop_count_q  <= 16'd0;
            sync_err_q    <= 1'b0;
            host_valid_q  <= 1'b0;
            rd_bank_q     <= 1'b1;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_bank_q     <= wr_bank_d;
            lock_q        <= lock_d;
            frame_ready_q <= frame_ready_d;
            frame_seq_q   <= frame_seq_d;
            drop_count_q  <= drop_count_d;
            sync_err_q    <= sync_err_d;
            host_valid_q  <= host_valid_d;
            rd_bank_q     <= rd_bank_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    assign w_we0 = w_wr_en && !wr_bank_q;
    assign w_we1 = w_wr_en &&  wr_bank_q;
    assign w_re0 = host_rd_en && !w_rd_oor &&  wr_bank_q;
    assign w_re1 = host_rd_en && !w_rd_oor && !wr_bank_q;

    snapshot_bank #(
        .WIDTH         (WORD_W),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_bank0 (
        .clk   (clk),
        .we    (w_we0),
        .waddr (w_wr_addr),
        .wdata (in_data),
        .re    (w_re0),
        .raddr (host_addr),
        .rdata (w_rdata0)
    );

    snapshot_bank #(
        .WIDTH         (WORD_W),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_bank1 (
        .clk   (clk),
        .we    (w_we1),
        .waddr (w_wr_addr),
        .wdata (in_data),
        .re    (w_re1),
        .raddr (host_addr),
        .rdata (w_rdata1)
    );

    assign host_data   = rd_zero_q ? '0 : (rd_bank_q ? w_rdata1 : w_rdata0);
    assign host_valid  = host_valid_q;
    assign frame_ready = frame_ready_q;
    assign frame_seq   = frame_seq_q;
    assign drop_count  = drop_count_q;
    assign sync_err    = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_field_snapshot_buffer.sv
// ============================================================================
// Module      : tb_field_snapshot_buffer
// Description : Directed self-checking bench for field_snapshot_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_field_snapshot_buffer;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int DP = 4;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [NC*DW-1:0]  in_data;
    logic              host_lock;
    logic              host_rd_en;
    logic [AW-1:0]     host_addr;
    logic [NC*DW-1:0]  host_data;
    logic              host_valid;
    logic              frame_ready;
    logic [15:0]       frame_seq;
    logic [15:0]       drop_count;
    logic              sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    field_snapshot_buffer #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (NC),
        .DEPTH         (DP),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .host_lock   (host_lock),
        .host_rd_en  (host_rd_en),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_valid  (host_valid),
        .frame_ready (frame_ready),
        .frame_seq   (frame_seq),
        .drop_count  (drop_count),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sof, input int p);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = {DW'(3 * p), DW'(2 * p), DW'(p)};
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input int base);
        beat(1'b1, base);
        for (int i = 1; i < DP; i++) beat(1'b0, base + i);
    endtask

    task automatic rd(input string tag, input int addr, input logic [47:0] exp);
        host_rd_en = 1'b1;
        host_addr  = AW'(addr);
        tick();
        host_rd_en = 1'b0;
        chk({tag, "_valid"}, 64'(host_valid), 64'd1);
        chk({tag, "_data"}, 64'(host_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        host_lock = 1'b0; host_rd_en = 1'b0; host_addr = '0;
        tick(); tick();
        chk("rst_valid", 64'(host_valid), 64'd0);
        chk("rst_data", 64'(host_data), 64'd0);
        chk("rst_ready", 64'(frame_ready), 64'd0);
        chk("rst_seq", 64'(frame_seq), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_sync", 64'(sync_err), 64'd0);
        rst = 1'b1;

        // Frame 1: pixel p carries {3p,2p,p}
        beat(1'b1, 0); beat(1'b0, 1); beat(1'b0, 2);
        chk("f1_not_ready", 64'(frame_ready), 64'd0);
        beat(1'b0, 3);
        chk("f1_ready", 64'(frame_ready), 64'd1);
        chk("f1_seq", 64'(frame_seq), 64'd1);
        rd("f1_rd2", 2, 48'h0006_0004_0002);
        tick();
        chk("f1_valid_drop", 64'(host_valid), 64'd0);
        chk("f1_data_hold", 64'(host_data), 64'h0006_0004_0002);

        // Frame 2 with lock raised mid-frame, then two dropped frames
        beat(1'b1, 10); beat(1'b0, 11);
        host_lock = 1'b1;
        tick();
        chk("lock_clears_ready", 64'(frame_ready), 64'd0);
        beat(1'b0, 12); beat(1'b0, 13);
        chk("f2_held_seq", 64'(frame_seq), 64'd1);
        frame(20);
        frame(30);
        chk("drop_cnt", 64'(drop_count), 64'd2);
        chk("hold_seq", 64'(frame_seq), 64'd1);
        rd("locked_rd1", 1, 48'h0003_0002_0001);
        host_lock = 1'b0;
        tick();
        chk("unlock_seq", 64'(frame_seq), 64'd2);
        chk("unlock_ready", 64'(frame_ready), 64'd1);
        rd("f2_rd3", 3, 48'h0027_001A_000D);

        // Mid-frame sof restarts the frame
        beat(1'b1, 40); beat(1'b0, 41); beat(1'b1, 50);
        chk("sync_err", 64'(sync_err), 64'd1);
        beat(1'b0, 51);
        chk("restart_no_swap", 64'(frame_seq), 64'd2);
        beat(1'b0, 52); beat(1'b0, 53);
        chk("restart_seq", 64'(frame_seq), 64'd3);
        rd("restart_rd0", 0, 48'h0096_0064_0032);
        rd("restart_rd3", 3, 48'h009F_006A_0035);

        // Completion on the same edge as a lock rise
        beat(1'b1, 60); beat(1'b0, 61); beat(1'b0, 62);
        host_lock = 1'b1;
        beat(1'b0, 63);
        chk("coinc_seq", 64'(frame_seq), 64'd3);
        chk("coinc_ready", 64'(frame_ready), 64'd0);
        rd("coinc_rd3", 3, 48'h009F_006A_0035);
        host_lock = 1'b0;
        tick();
        chk("coinc_hold_swap", 64'(frame_seq), 64'd4);
        rd("coinc_rd0", 0, 48'h00B4_0078_003C);

        // Out-of-range read
        rd("oor_rd5", 5, 48'h0);

        // Reset in the middle of a frame
        beat(1'b1, 70); beat(1'b0, 71);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_valid", 64'(host_valid), 64'd0);
        chk("mrst_data", 64'(host_data), 64'd0);
        chk("mrst_ready", 64'(frame_ready), 64'd0);
        chk("mrst_seq", 64'(frame_seq), 64'd0);
        chk("mrst_drop", 64'(drop_count), 64'd0);
        chk("mrst_sync", 64'(sync_err), 64'd0);
        beat(1'b0, 72); beat(1'b0, 73);
        chk("idle_ignores", 64'(frame_seq), 64'd0);
        frame(80);
        chk("post_rst_seq", 64'(frame_seq), 64'd1);
        chk("post_rst_ready", 64'(frame_ready), 64'd1);
        rd("post_rst_rd2", 2, 48'h00F6_00A4_0052);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
